// File: rtl/output_mixer_pkg.sv
// Shared constants and types for the output mixer.
//   MIXER_GAIN_WIDTH / MIXER_GAIN_FRAC : default gain word format (unsigned Q2.6)
//   MIXER_UNITY_GAIN                  : gain code that passes a channel unchanged
//   mixer_state_t                     : sequencer states of the shared MAC
package output_mixer_pkg;

    localparam int MIXER_GAIN_WIDTH = 8;
    localparam int MIXER_GAIN_FRAC  = 6;
    localparam int MIXER_UNITY_GAIN = 2 ** MIXER_GAIN_FRAC;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCUM  = 2'd1,
        FINISH = 2'd2
    } mixer_state_t;

endpackage

// File: rtl/mixer_saturate.sv
// Drops the gain fraction from a wide accumulator and clamps to the output range.
//   acc     : signed accumulator value (ACC_WIDTH bits)
//   sat     : acc >>> SHIFT, clamped to signed OUT_WIDTH
//   clipped : high when the clamp actually changed the value
// Purely combinational. Assumes ACC_WIDTH - SHIFT >= OUT_WIDTH.
module mixer_saturate #(
    parameter int ACC_WIDTH = 28,
    parameter int SHIFT     = 6,
    parameter int OUT_WIDTH = 16
) (
    input  logic signed [ACC_WIDTH-1:0] acc,
    output logic signed [OUT_WIDTH-1:0] sat,
    output logic                        clipped
);

    logic signed [ACC_WIDTH-1:0]         scaled;
    logic        [ACC_WIDTH-OUT_WIDTH:0] high_bits;
    logic                                in_range;

    // Arithmetic shift rounds toward minus infinity, which is the intended floor.
    assign scaled    = acc >>> SHIFT;
    // The value fits when every bit from the output sign bit upward is a sign copy.
    assign high_bits = scaled[ACC_WIDTH-1:OUT_WIDTH-1];
    assign in_range  = (&high_bits) | ~(|high_bits);
    assign clipped   = ~in_range;

    always_comb begin
        if (in_range) begin
            sat = scaled[OUT_WIDTH-1:0];
        end else if (scaled[ACC_WIDTH-1]) begin
            sat = {1'b1, {(OUT_WIDTH-1){1'b0}}};
        end else begin
            sat = {1'b0, {(OUT_WIDTH-1){1'b1}}};
        end
    end

endmodule

// File: rtl/output_mixer.sv
// Stereo output mixer: one shared multiply-accumulate walks the channels once
// per sample_clk_en, then both sums are scaled down by the gain fraction and
// saturated to OUT_WIDTH.
//   clk, reset              : system clock, synchronous active-high reset
//   sample_clk_en           : strobe that snapshots the inputs and starts a mix
//   channel_in / gain       : per-channel signed sample and unsigned gain
//   route_l / route_r       : per-channel left/right enables
//   status_clr              : clears clip_l, clip_r and overrun
//   sample_l / sample_r     : mixed outputs, held until the next mix completes
//   sample_valid            : one-cycle pulse when sample_l/sample_r update
//   busy                    : mix in progress
//   clip_l / clip_r/overrun : sticky status for the host
module output_mixer
    import output_mixer_pkg::*;
#(
    parameter int NUM_CHANNELS = 4,
    parameter int IN_WIDTH     = 16,
    parameter int OUT_WIDTH    = 16,
    parameter int GAIN_WIDTH   = MIXER_GAIN_WIDTH,
    parameter int GAIN_FRAC    = MIXER_GAIN_FRAC
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        sample_clk_en,
    input  logic signed [IN_WIDTH-1:0]  channel_in [NUM_CHANNELS],
    input  logic [GAIN_WIDTH-1:0]       gain       [NUM_CHANNELS],
    input  logic [NUM_CHANNELS-1:0]     route_l,
    input  logic [NUM_CHANNELS-1:0]     route_r,
    input  logic                        status_clr,
    output logic signed [OUT_WIDTH-1:0] sample_l,
    output logic signed [OUT_WIDTH-1:0] sample_r,
    output logic                        sample_valid,
    output logic                        busy,
    output logic                        clip_l,
    output logic                        clip_r,
    output logic                        overrun
);

    localparam int PROD_WIDTH = IN_WIDTH + GAIN_WIDTH + 1;
    // Headroom for NUM_CHANNELS full-scale products so the sum cannot wrap.
    localparam int ACC_WIDTH  = PROD_WIDTH + $clog2(NUM_CHANNELS + 1);
    localparam int IDX_WIDTH  = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;
    localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(NUM_CHANNELS - 1);

    mixer_state_t state_q, state_d;

    logic signed [IN_WIDTH-1:0]   snap_in      [NUM_CHANNELS];
    logic [GAIN_WIDTH-1:0]        snap_gain    [NUM_CHANNELS];
    logic [NUM_CHANNELS-1:0]      snap_route_l;
    logic [NUM_CHANNELS-1:0]      snap_route_r;

    logic [IDX_WIDTH-1:0]         idx_q;
    logic signed [ACC_WIDTH-1:0]  acc_l_q, acc_r_q;
    logic signed [PROD_WIDTH-1:0] prod;

    logic                         load, acc_en, finish;
    logic signed [OUT_WIDTH-1:0]  sat_l, sat_r;
    logic                         clipped_l, clipped_r;
    logic                         overrun_set;

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: every combinational output gets a default first so no path leaves
    // a signal unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        acc_en  = 1'b0;
        finish  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (sample_clk_en) begin
                    load    = 1'b1;
                    state_d = ACCUM;
                end
            end
            ACCUM: begin
                acc_en = 1'b1;
                if (idx_q == LAST_IDX) begin
                    state_d = FINISH;
                end
            end
            FINISH: begin
                finish  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy = (state_q != IDLE);
    // A strobe during FINISH also counts: that mix has not yet returned to IDLE.
    assign overrun_set = sample_clk_en && (state_q != IDLE);

    // ----------------------------------------------------------- snapshot
    // NOTE: the snapshot is deliberately left out of reset; it is always
    // reloaded before use, so resetting it would only add reset fan-out.
    always_ff @(posedge clk) begin
        if (load) begin
            snap_in      <= channel_in;
            snap_gain    <= gain;
            snap_route_l <= route_l;
            snap_route_r <= route_r;
        end
    end

    // Zero-extend the gain before the signed multiply so codes >= 128 stay positive.
    assign prod = PROD_WIDTH'(snap_in[idx_q]) *
                  PROD_WIDTH'($signed({1'b0, snap_gain[idx_q]}));

    // ----------------------------------------------------------- datapath
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            idx_q        <= '0;
            acc_l_q      <= '0;
            acc_r_q      <= '0;
            sample_l     <= '0;
            sample_r     <= '0;
            sample_valid <= 1'b0;
            clip_l       <= 1'b0;
            clip_r       <= 1'b0;
            overrun      <= 1'b0;
        end else begin
            sample_valid <= finish;

            if (load) begin
                idx_q   <= '0;
                acc_l_q <= '0;
                acc_r_q <= '0;
            end else if (acc_en) begin
                if (snap_route_l[idx_q]) acc_l_q <= acc_l_q + ACC_WIDTH'(prod);
                if (snap_route_r[idx_q]) acc_r_q <= acc_r_q + ACC_WIDTH'(prod);
                idx_q <= (idx_q == LAST_IDX) ? '0 : idx_q + 1'b1;
            end

            if (finish) begin
                sample_l <= sat_l;
                sample_r <= sat_r;
            end

            // Sticky bits: a set in the same cycle as a clear wins.
            if (finish && clipped_l) clip_l <= 1'b1;
            else if (status_clr)     clip_l <= 1'b0;

            if (finish && clipped_r) clip_r <= 1'b1;
            else if (status_clr)     clip_r <= 1'b0;

            if (overrun_set)         overrun <= 1'b1;
            else if (status_clr)     overrun <= 1'b0;
        end
    end

    mixer_saturate #(
        .ACC_WIDTH (ACC_WIDTH),
        .SHIFT     (GAIN_FRAC),
        .OUT_WIDTH (OUT_WIDTH)
    ) u_sat_l (
        .acc     (acc_l_q),
        .sat     (sat_l),
        .clipped (clipped_l)
    );

    mixer_saturate #(
        .ACC_WIDTH (ACC_WIDTH),
        .SHIFT     (GAIN_FRAC),
        .OUT_WIDTH (OUT_WIDTH)
    ) u_sat_r (
        .acc     (acc_r_q),
        .sat     (sat_r),
        .clipped (clipped_r)
    );

endmodule

// File: tb/tb_output_mixer.sv
module tb_output_mixer;

    localparam int N = 4;

    logic               clk = 1'b0;
    logic               reset;
    logic               sample_clk_en;
    logic signed [15:0] ch [N];
    logic [7:0]         gn [N];
    logic [N-1:0]       rl, rr;
    logic               status_clr;
    logic signed [15:0] sample_l, sample_r;
    logic               sample_valid, busy, clip_l, clip_r, overrun;

    int errors = 0;
    int checks = 0;

    // Reference snapshot taken by the bench when it launches a mix.
    logic signed [15:0] m_ch [N];
    logic [7:0]         m_gn [N];
    logic [N-1:0]       m_rl, m_rr;

    output_mixer dut (
        .clk           (clk),
        .reset         (reset),
        .sample_clk_en (sample_clk_en),
        .channel_in    (ch),
        .gain          (gn),
        .route_l       (rl),
        .route_r       (rr),
        .status_clr    (status_clr),
        .sample_l      (sample_l),
        .sample_r      (sample_r),
        .sample_valid  (sample_valid),
        .busy          (busy),
        .clip_l        (clip_l),
        .clip_r        (clip_r),
        .overrun       (overrun)
    );

    always #5 clk = ~clk;

    // Mix one side from the snapshot: sum of in*gain, floor-divide by 64, clamp.
    function automatic int model_side(input logic [N-1:0] route, output bit clipped);
        longint sum = 0;
        longint v;
        for (int i = 0; i < N; i++) begin
            if (route[i]) sum += longint'(m_ch[i]) * longint'(m_gn[i]);
        end
        v = sum >>> 6;
        clipped = 1'b0;
        if (v > 32767)  begin v = 32767;  clipped = 1'b1; end
        if (v < -32768) begin v = -32768; clipped = 1'b1; end
        return int'(v);
    endfunction

    task automatic randomize_inputs();
        for (int i = 0; i < N; i++) begin
            ch[i] = 16'($urandom);
            gn[i] = 8'($urandom);
        end
        rl = 4'($urandom);
        rr = 4'($urandom);
    endtask

    // Launches a mix on the next negedge; cnt counts rising edges since the
    // launching edge. Optional second strobe, input change, clear and reset
    // can be placed at given cycles (-1 disables).
    task automatic run_mix(input int en2_at, input int change_at, input int clr_at,
                           input int rst_at, output int n_valid, output int first_valid,
                           output bit busy_seen);
        m_ch = ch; m_gn = gn; m_rl = rl; m_rr = rr;
        n_valid = 0; first_valid = -1; busy_seen = 1'b0;
        @(negedge clk);
        sample_clk_en = 1'b1;
        for (int cnt = 1; cnt <= 14; cnt++) begin
            @(negedge clk);
            sample_clk_en = (cnt == en2_at);
            status_clr    = (cnt == clr_at);
            reset         = (cnt == rst_at);
            if (cnt == change_at) randomize_inputs();
            if (cnt == 1 && busy) busy_seen = 1'b1;
            if (sample_valid) begin
                n_valid++;
                if (first_valid < 0) first_valid = cnt;
                if (busy) begin
                    errors++;
                    $display("FAIL busy_at_valid: busy=%0d required 0", busy);
                end
                checks++;
            end
        end
        sample_clk_en = 1'b0; status_clr = 1'b0; reset = 1'b0;
    endtask

    task automatic pulse_clr();
        @(negedge clk); status_clr = 1'b1;
        @(negedge clk); status_clr = 1'b0;
    endtask

    task automatic set_all(input int a0, input int a1, input int a2, input int a3,
                           input int g, input logic [N-1:0] l, input logic [N-1:0] r);
        ch[0] = 16'(a0); ch[1] = 16'(a1); ch[2] = 16'(a2); ch[3] = 16'(a3);
        for (int i = 0; i < N; i++) gn[i] = 8'(g);
        rl = l; rr = r;
    endtask

    task automatic check_val(input string name, input int got, input int exp);
        // thin formatter only; comparisons stay inline in each test
        $display("FAIL %s: got %0d required %0d", name, got, exp);
    endtask

    task automatic test_reset();
        reset = 1'b1; sample_clk_en = 1'b0; status_clr = 1'b0;
        set_all(0, 0, 0, 0, 64, '0, '0);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if ({sample_l, sample_r} !== 32'd0) begin
            errors++; check_val("reset_samples", {sample_l, sample_r}, 0);
        end
        checks++;
        if ({sample_valid, busy, clip_l, clip_r, overrun} !== 5'b0) begin
            errors++; check_val("reset_flags", {sample_valid, busy, clip_l, clip_r, overrun}, 0);
        end
    endtask

    task automatic test_unity_routing();
        int nv, fv; bit bs;
        set_all(1000, -2000, 3000, 500, 64, 4'b0101, 4'b1010);
        run_mix(-1, -1, -1, -1, nv, fv, bs);
        checks++; if (sample_l !== 16'sd4000)  begin errors++; check_val("unity_l", sample_l, 4000); end
        checks++; if (sample_r !== -16'sd1500) begin errors++; check_val("unity_r", sample_r, -1500); end
        checks++; if (fv !== 6)                begin errors++; check_val("latency", fv, 6); end
        checks++; if (nv !== 1)                begin errors++; check_val("valid_width", nv, 1); end
        checks++; if (!bs)                     begin errors++; check_val("busy_after_en", bs, 1); end
        checks++; if (overrun !== 1'b0)        begin errors++; check_val("no_overrun", overrun, 0); end
    endtask

    task automatic test_clip();
        int nv, fv; bit bs;
        pulse_clr();
        set_all(20000, 0, 20000, 0, 64, 4'b0101, 4'b0000);
        run_mix(-1, -1, -1, -1, nv, fv, bs);
        checks++; if (sample_l !== 16'sd32767) begin errors++; check_val("clip_pos_l", sample_l, 32767); end
        checks++; if (sample_r !== 16'sd0)     begin errors++; check_val("unrouted_r", sample_r, 0); end
        checks++; if (clip_l !== 1'b1)         begin errors++; check_val("clip_l_set", clip_l, 1); end
        checks++; if (clip_r !== 1'b0)         begin errors++; check_val("clip_r_clear", clip_r, 0); end
        set_all(-20000, 0, -20000, 0, 64, 4'b0101, 4'b0000);
        run_mix(-1, -1, -1, -1, nv, fv, bs);
        checks++; if (sample_l !== -16'sd32768) begin errors++; check_val("clip_neg_l", sample_l, -32768); end
    endtask

    task automatic test_gain_floor();
        int nv, fv; bit bs;
        pulse_clr();
        set_all(1000, 0, 0, 0, 32, 4'b0001, 4'b0000);
        run_mix(-1, -1, -1, -1, nv, fv, bs);
        checks++; if (sample_l !== 16'sd500) begin errors++; check_val("half_gain", sample_l, 500); end
        ch[0] = -16'sd3;
        run_mix(-1, -1, -1, -1, nv, fv, bs);
        checks++; if (sample_l !== -16'sd2) begin errors++; check_val("floor_neg", sample_l, -2); end
        checks++; if ({clip_l, clip_r} !== 2'b00) begin errors++; check_val("floor_no_clip", {clip_l, clip_r}, 0); end
    endtask

    task automatic test_both_sides_status();
        int nv, fv; bit bs;
        set_all(-32768, 0, 0, 0, 0, 4'b0001, 4'b0001);
        gn[0] = 8'd255;
        run_mix(-1, -1, -1, -1, nv, fv, bs);
        checks++; if (sample_l !== -16'sd32768) begin errors++; check_val("both_l", sample_l, -32768); end
        checks++; if (sample_r !== -16'sd32768) begin errors++; check_val("both_r", sample_r, -32768); end
        checks++; if ({clip_l, clip_r} !== 2'b11) begin errors++; check_val("both_clip", {clip_l, clip_r}, 3); end
        @(negedge clk); status_clr = 1'b1;
        @(negedge clk); status_clr = 1'b0;
        checks++; if ({clip_l, clip_r} !== 2'b00) begin errors++; check_val("clr_next_cycle", {clip_l, clip_r}, 0); end
        // clear asserted in the FINISH cycle, when the new clip is recorded
        run_mix(-1, -1, 5, -1, nv, fv, bs);
        checks++; if ({clip_l, clip_r} !== 2'b11) begin errors++; check_val("set_wins", {clip_l, clip_r}, 3); end
    endtask

    task automatic test_overrun();
        int nv, fv, el, er; bit bs, cl, cr;
        pulse_clr();
        set_all(1200, -700, 300, 2500, 64, 4'b0111, 4'b1100);
        gn[1] = 8'd100; gn[3] = 8'd17;
        run_mix(3, 2, -1, -1, nv, fv, bs);
        el = model_side(m_rl, cl);
        er = model_side(m_rr, cr);
        checks++; if (overrun !== 1'b1)   begin errors++; check_val("overrun_set", overrun, 1); end
        checks++; if (nv !== 1)           begin errors++; check_val("overrun_one_valid", nv, 1); end
        checks++; if (fv !== 6)           begin errors++; check_val("overrun_latency", fv, 6); end
        checks++; if (sample_l !== 16'(el)) begin errors++; check_val("overrun_snap_l", sample_l, el); end
        checks++; if (sample_r !== 16'(er)) begin errors++; check_val("overrun_snap_r", sample_r, er); end
        // strobe landing in the FINISH cycle
        pulse_clr();
        run_mix(5, -1, -1, -1, nv, fv, bs);
        checks++; if (overrun !== 1'b1) begin errors++; check_val("overrun_finish", overrun, 1); end
        checks++; if (nv !== 1)         begin errors++; check_val("finish_en_ignored", nv, 1); end
    endtask

    task automatic test_reset_mid_mix();
        int nv, fv, el, er; bit bs, cl, cr;
        set_all(9000, 8000, -7000, 6000, 64, 4'b1111, 4'b0011);
        run_mix(-1, -1, -1, 3, nv, fv, bs);
        checks++; if (nv !== 0) begin errors++; check_val("reset_no_valid", nv, 0); end
        checks++;
        if ({sample_l, sample_r} !== 32'd0 || {busy, clip_l, clip_r, overrun} !== 4'b0) begin
            errors++; check_val("reset_mid_values", {busy, clip_l, clip_r, overrun}, 0);
        end
        run_mix(-1, -1, -1, -1, nv, fv, bs);
        el = model_side(m_rl, cl);
        er = model_side(m_rr, cr);
        checks++; if (fv !== 6 || nv !== 1) begin errors++; check_val("after_reset_latency", fv, 6); end
        checks++; if (sample_l !== 16'(el)) begin errors++; check_val("after_reset_l", sample_l, el); end
        checks++; if (sample_r !== 16'(er)) begin errors++; check_val("after_reset_r", sample_r, er); end
    endtask

    task automatic test_random();
        int nv, fv, el, er; bit bs, cl, cr;
        for (int k = 0; k < 40; k++) begin
            pulse_clr();
            randomize_inputs();
            if (k % 4 == 0) for (int i = 0; i < N; i++) gn[i] = 8'($urandom_range(0, 40));
            run_mix(-1, -1, -1, -1, nv, fv, bs);
            el = model_side(m_rl, cl);
            er = model_side(m_rr, cr);
            checks++; if (sample_l !== 16'(el)) begin errors++; check_val("rand_l", sample_l, el); end
            checks++; if (sample_r !== 16'(er)) begin errors++; check_val("rand_r", sample_r, er); end
            checks++; if ({clip_l, clip_r} !== {cl, cr}) begin errors++; check_val("rand_clip", {clip_l, clip_r}, {cl, cr}); end
            checks++; if (nv !== 1 || fv !== 6) begin errors++; check_val("rand_timing", fv, 6); end
        end
    endtask

    initial begin
        test_reset();
        test_unity_routing();
        test_clip();
        test_gain_floor();
        test_both_sides_status();
        test_overrun();
        test_reset_mid_mix();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/output_mixer.md
Name: output_mixer

Overview:
- Parametrised successor to the fixed four-channel add-and-clamp stage that sits between `channels` and `i2s`.
- Mixes NUM_CHANNELS signed channel outputs into one stereo pair, with per-channel unsigned fixed-point gain and per-channel left/right routing.
- Uses one shared multiply-accumulate unit, run sequentially over the channels once per sample_clk_en, followed by rounding-free scaling and saturation to OUT_WIDTH.
- Provides sticky clip and overrun status bits for the host register interface.

Parameters:
- NUM_CHANNELS, 4, number of channel inputs mixed (≥1).
- IN_WIDTH, 16, signed width of each channel input.
- OUT_WIDTH, 16, signed width of sample_l/sample_r.
- GAIN_WIDTH, 8, unsigned width of each gain word.
- GAIN_FRAC, 6, fractional bits in gain; unity gain = 2**GAIN_FRAC (64).

Ports:
- clk  in  1  system clock (12.727 MHz domain).
- reset  in  1  synchronous, active-high reset.
- sample_clk_en  in  1  one-cycle strobe that starts a mix.
- channel_in[NUM_CHANNELS]  in  IN_WIDTH each, signed  channel samples.
- gain[NUM_CHANNELS]  in  GAIN_WIDTH each, unsigned  per-channel gain.
- route_l[NUM_CHANNELS]  in  1 each  channel contributes to the left output.
- route_r[NUM_CHANNELS]  in  1 each  channel contributes to the right output.
- status_clr  in  1  clears clip_l, clip_r and overrun.
- sample_l  out  OUT_WIDTH signed  mixed left sample.
- sample_r  out  OUT_WIDTH signed  mixed right sample.
- sample_valid  out  1  one-cycle pulse when sample_l/sample_r update.
- busy  out  1  high while a mix is in progress.
- clip_l  out  1  sticky: left output saturated since the last clear.
- clip_r  out  1  sticky: right output saturated since the last clear.
- overrun  out  1  sticky: sample_clk_en arrived while busy.

Behaviour:
- Reset (synchronous, active-high):
  - state = IDLE.
  - sample_l = sample_r = 0.
  - sample_valid, busy, clip_l, clip_r, overrun = 0.
  - Accumulators and channel index cleared.
- States: IDLE -> ACCUM -> FINISH -> IDLE.
- IDLE, at the edge where sample_clk_en=1 (cycle T):
  - Snapshot channel_in, gain, route_l and route_r into internal registers.
  - Clear acc_l and acc_r; set idx=0; go to ACCUM.
  - busy=1 from T+1.
- ACCUM, cycles T+1 .. T+NUM_CHANNELS:
  - prod = snap_in[idx] * signed({1'b0, snap_gain[idx]}), width IN_WIDTH+GAIN_WIDTH+1.
  - acc_l += prod if snap_route_l[idx]; acc_r += prod if snap_route_r[idx].
  - idx++; after idx = NUM_CHANNELS-1, go to FINISH.
- Accumulator width: IN_WIDTH+GAIN_WIDTH+1+$clog2(NUM_CHANNELS+1). It must never overflow internally.
- FINISH, cycle T+NUM_CHANNELS+1:
  - Compute scaled = acc >>> GAIN_FRAC (arithmetic shift, floor).
  - Saturate scaled to [-2**(OUT_WIDTH-1), 2**(OUT_WIDTH-1)-1].
  - Register into sample_l/sample_r; go to IDLE.
- Output timing:
  - sample_l, sample_r and sample_valid=1 are visible in cycle T+NUM_CHANNELS+2. Latency = NUM_CHANNELS+2 clocks.
  - sample_valid is high for exactly one cycle.
  - sample_l/sample_r hold their value until the next FINISH.
  - busy falls in the same cycle that sample_valid rises.
- Clip: clip_l/clip_r set when the corresponding saturation actually limits the value.
- Unrouted channels contribute 0. A channel routed to both sides contributes to both.
- A side with no routed channels outputs 0.
- sample_clk_en while state != IDLE:
  - Ignored (no restart, snapshot unchanged); overrun set.
  - sample_clk_en in the same cycle as FINISH's return to IDLE is also an overrun.
- status_clr: clears the sticky bits next cycle. If a set condition occurs in the same cycle, set wins.
- Input changes during a mix have no effect; only the snapshot is used.
- Reset mid-mix: abort immediately and apply reset values; no sample_valid is produced.
- Integration requirement: the sample_clk_en period must exceed NUM_CHANNELS+2 clocks. At the current 256-clock period this allows NUM_CHANNELS up to 253.

Decomposition:
- opl3_pkg additions:
  - MIXER_GAIN_WIDTH and MIXER_GAIN_FRAC constants.
  - MIXER_UNITY_GAIN = 2**MIXER_GAIN_FRAC.
  - typedef enum mixer_state_t {IDLE, ACCUM, FINISH}.
- Sub-module mixer_saturate, instantiated twice (left and right):
  - Parameters ACC_WIDTH, SHIFT, OUT_WIDTH.
  - Combinational shift plus clamp.
  - Outputs the saturated value and a clipped flag.

Test Plan:
- Unity gains (64), route ch0/ch2 left and ch1/ch3 right; inputs 1000, -2000, 3000, 500:
  - sample_l=4000, sample_r=-1500.
  - sample_valid exactly 6 cycles after the en edge, one cycle wide.
- Unity gains, ch0=ch2=20000 routed left -> sample_l=32767, clip_l=1, clip_r=0. Then ch0=ch2=-20000 -> sample_l=-32768.
- Gain 32 on ch0 only:
  - ch0=1000 -> sample_l=500.
  - ch0=-3 -> sample_l=-2 (floor); clip bits stay 0.
- ch0 routed to both sides, gain 255, ch0=-32768:
  - Both sides = -32768 (floor(-130560) saturated); clip_l=clip_r=1.
  - status_clr pulse -> both clear next cycle.
  - status_clr in the same cycle as a new clip -> bit stays 1.
- sample_clk_en at cycles 0 and 3 -> overrun=1, exactly one sample_valid (cycle 6), result from the cycle-0 snapshot. Changing inputs at cycle 2 does not alter the result.
- Reset asserted at cycle 3 of a mix:
  - All outputs return to reset values; no sample_valid follows.
  - The next sample_clk_en produces a correct mix after 6 cycles.
